// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the DMAC secondary-port memory responder.
package ext_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic WR     = 1'b1;
  localparam logic RD     = 1'b0;
  localparam int   WAIT_W = 4;

  // Wait states that apply to an access of the given direction.
  function automatic logic [WAIT_W-1:0] wait_of(input logic                wr_rd,
                                                input logic [WAIT_W-1:0] rd_wait,
                                                input logic [WAIT_W-1:0] wr_wait);
    return (wr_rd == WR) ? wr_wait : rd_wait;
  endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Single-port synchronous RAM; the read register only updates on re_i and is
// cleared by reset, while the storage itself is never reset.
module ext_mem_array #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   dout_q <= '0;
    else if (re_i) dout_q <= mem_q[addr_i];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Wait-state memory responder on the DMAC secondary port (IDLE -> BUSY -> DONE).
// Optional per-direction access counters are built when EXT_MEM_ACCESS_CNT_EN is defined.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int DMA_SIZE   = 16,
  parameter int DMD_SIZE   = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_rd,
  input  logic [DMA_SIZE-1:0] addr,
  input  logic [DMD_SIZE-1:0] din,
  output logic [DMD_SIZE-1:0] dout,
  output logic                stall,
  output logic                ack,
  output state_e              state_dbg
`ifdef EXT_MEM_ACCESS_CNT_EN
  ,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt
`endif
);

  localparam logic [WAIT_W-1:0] RD_W = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_W = WAIT_W'(WR_WAIT);

  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [DMD_SIZE-1:0]     din_q;
  logic                    wr_q;
  logic [WAIT_W-1:0]       w_in;
  logic                    cap, fire;
  logic [DEPTH_LOG2-1:0]   mem_addr;
  logic [DMD_SIZE-1:0]     mem_din;
  logic                    mem_wr;

  assign w_in = wait_of(wr_rd, RD_W, WR_W);

  // Upper address bits alias onto the RAM and are deliberately dropped.
  if (DMA_SIZE > DEPTH_LOG2) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[DMA_SIZE-1:DEPTH_LOG2];
  end

  // A zero-wait access completes on its capture edge, so the RAM must see the
  // live bus rather than the not-yet-loaded capture registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap      = 1'b0;
    fire     = 1'b0;
    stall    = 1'b0;
    ack      = 1'b0;
    mem_addr = addr_q;
    mem_din  = din_q;
    mem_wr   = wr_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          cap   = 1'b1;
          stall = (w_in != '0);
          if (w_in == '0) begin
            state_d  = DONE;
            cnt_d    = '0;
            fire     = 1'b1;
            mem_addr = addr[DEPTH_LOG2-1:0];
            mem_din  = din;
            mem_wr   = wr_rd;
          end else begin
            state_d = BUSY;
            cnt_d   = w_in - 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= RD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        addr_q <= addr[DEPTH_LOG2-1:0];
        din_q  <= din;
        wr_q   <= wr_rd;
      end
    end
  end

  ext_mem_array #(
    .AW (DEPTH_LOG2),
    .DW (DMD_SIZE)
  ) u_array (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (fire & (mem_wr == WR)),
    .re_i   (fire & (mem_wr == RD)),
    .addr_i (mem_addr),
    .din_i  (mem_din),
    .dout_o (dout)
  );

  assign state_dbg = state_q;

`ifdef EXT_MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == DONE) begin
      if (wr_q == WR) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench: dut_a uses RD_WAIT=2/WR_WAIT=1, dut_b is the zero-wait build.
// Counter checks are compiled in when EXT_MEM_ACCESS_CNT_EN is defined.
module tb_ext_mem_responder;
  import ext_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_a = 1'b0, wr_a = 1'b0;
  logic [15:0] addr_a = '0, din_a = '0;
  logic [15:0] dout_a;
  logic        stall_a, ack_a;
  state_e      st_a;

  logic        en_b = 1'b0, wr_b = 1'b0;
  logic [15:0] addr_b = '0, din_b = '0;
  logic [15:0] dout_b;
  logic        stall_b, ack_b;
  state_e      st_b;

`ifdef EXT_MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  ext_mem_responder #(
    .DMA_SIZE(16), .DMD_SIZE(16), .DEPTH_LOG2(8), .RD_WAIT(2), .WR_WAIT(1)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .wr_rd(wr_a), .addr(addr_a), .din(din_a),
    .dout(dout_a), .stall(stall_a), .ack(ack_a), .state_dbg(st_a)
`ifdef EXT_MEM_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a)
`endif
  );

  ext_mem_responder #(
    .DMA_SIZE(16), .DMD_SIZE(16), .DEPTH_LOG2(8), .RD_WAIT(0), .WR_WAIT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .wr_rd(wr_b), .addr(addr_b), .din(din_b),
    .dout(dout_b), .stall(stall_b), .ack(ack_b), .state_dbg(st_b)
`ifdef EXT_MEM_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b)
`endif
  );

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // dut_a access: request cycle, W busy cycles, DONE, back in IDLE.
  // Bus inputs are scrambled after capture to prove they are not re-sampled.
  task automatic acc_a(input logic wr, input logic [15:0] a, input logic [15:0] d);
    int w;
    w = wr ? 1 : 2;
    en_a = 1'b1; wr_a = wr; addr_a = a; din_a = d;
    #1;
    chk("a_req_stall", stall_a, 1);
    chk("a_req_ack", ack_a, 0);
    @(posedge clk); #1;
    en_a = 1'b0; addr_a = ~a; din_a = ~d;
    #1;
    for (int k = 0; k < w; k++) begin
      chk("a_busy_stall", stall_a, 1);
      chk("a_busy_ack", ack_a, 0);
      chk("a_busy_state", 32'(st_a), 32'(BUSY));
      @(posedge clk); #2;
    end
    chk("a_done_ack", ack_a, 1);
    chk("a_done_stall", stall_a, 0);
    if (!wr) chk("a_rd_data", dout_a, exp_q.pop_front());
    @(posedge clk); #2;
    chk("a_idle_ack", ack_a, 0);
    chk("a_idle_state", 32'(st_a), 32'(IDLE));
  endtask

  // dut_b zero-wait access with en left high: DONE next cycle, then IDLE.
  task automatic acc_b(input logic wr, input logic [15:0] a, input logic [15:0] d);
    en_b = 1'b1; wr_b = wr; addr_b = a; din_b = d;
    #1;
    chk("b_req_stall", stall_b, 0);
    chk("b_req_ack", ack_b, 0);
    @(posedge clk); #1;
    chk("b_done_ack", ack_b, 1);
    chk("b_done_stall", stall_b, 0);
    if (!wr) chk("b_rd_data", dout_b, exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // 1: async reset pulse
    #2 rst = 1'b0;
    #0.5;
    chk("rst_dout_a", dout_a, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_stall_a", stall_a, 0);
    chk("rst_state_a", 32'(st_a), 32'(IDLE));
    chk("rst_dout_b", dout_b, 0);
    chk("rst_state_b", 32'(st_b), 32'(IDLE));
    #0.5 rst = 1'b1;
    @(posedge clk); #1;

    // 2: write then read back with wait states
    acc_a(1'b1, 16'h0010, 16'hA5A5);
    exp_q.push_back(16'hA5A5);
    acc_a(1'b0, 16'h0010, 16'h0000);

    // 4: alias, and dout holds across a write
    acc_a(1'b1, 16'h0103, 16'h1234);
    chk("a_dout_hold", dout_a, 16'hA5A5);
    exp_q.push_back(16'h1234);
    acc_a(1'b0, 16'h0003, 16'h0000);

    // 5: reset while the write is in BUSY aborts it
    en_a = 1'b1; wr_a = 1'b1; addr_a = 16'h0003; din_a = 16'hBEEF;
    @(posedge clk); #1;
    en_a = 1'b0;
    #1;
    chk("abort_busy", 32'(st_a), 32'(BUSY));
    rst = 1'b0;
    #1;
    chk("abort_state", 32'(st_a), 32'(IDLE));
    chk("abort_ack", ack_a, 0);
    chk("abort_stall", stall_a, 0);
    chk("abort_dout", dout_a, 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("abort_no_ack", ack_a, 0);
    end
    exp_q.push_back(16'h1234);
    acc_a(1'b0, 16'h0003, 16'h0000);

    // 3: zero-wait back-to-back with en held high
    @(posedge clk); #1;
    acc_b(1'b1, 16'h0000, 16'h1111);
    acc_b(1'b1, 16'h0001, 16'h2222);
    acc_b(1'b1, 16'h01FF, 16'h3333);
    exp_q.push_back(16'h1111);
    acc_b(1'b0, 16'h0000, 16'h0000);
    exp_q.push_back(16'h3333);
    acc_b(1'b0, 16'h00FF, 16'h0000);
    exp_q.push_back(16'h2222);
    acc_b(1'b0, 16'h0101, 16'h0000);
    en_b = 1'b0;
    #1;
    chk("b_idle_ack", ack_b, 0);
    chk("b_idle_state", 32'(st_b), 32'(IDLE));

`ifdef EXT_MEM_ACCESS_CNT_EN
    // 6: access counters
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("cnt_rst_wr", wr_cnt_a, 0);
    chk("cnt_rst_rd", rd_cnt_a, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    acc_a(1'b1, 16'h0020, 16'h0001);
    acc_a(1'b1, 16'h0021, 16'h0002);
    acc_a(1'b1, 16'h0022, 16'h0003);
    exp_q.push_back(16'h0001);
    acc_a(1'b0, 16'h0020, 16'h0000);
    exp_q.push_back(16'h0003);
    acc_a(1'b0, 16'h0022, 16'h0000);
    chk("cnt_wr", wr_cnt_a, 3);
    chk("cnt_rd", rd_cnt_a, 2);
    chk("cnt_b_untouched", wr_cnt_b, 0);
    rst = 1'b0; #1;
    chk("cnt_clr_wr", wr_cnt_a, 0);
    chk("cnt_clr_rd", rd_cnt_a, 0);
    rst = 1'b1;
`endif

    chk("exp_q_empty", 32'(exp_q.size()), 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
